multicycle_ctrl_unit: RTL and testbench
=======================================

Name: multicycle_ctrl_unit

Overview:
Parametrised multicycle RV32 control FSM that drives every datapath mux, register load and memory strobe of the processor core. It extends the fetch/decode control to the full R, I, load, store, branch (beq/bne), jal and lui instruction set. It adds configurable memory wait states, a post-reset idle period and an illegal-instruction trap path. All outputs are decoded from state (Moore) and default to 0 in every state.

Parameters:
- MEM_LAT, 0: extra wait cycles per instruction- or data-memory access (0..15).
- RESET_IDLE, 1: idle cycles after reset release before the first fetch (1..15).
- ALUOP_W, 3: ALUOp width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OpCode  in  7  instruction opcode from IR.
- Funct3  in  3  IR[14:12].
- Zero  in  1  ALU zero flag; informational only, gated in the datapath.
- pcWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by branch compare.
- BranchNeg  out  1  1 = bne (invert Zero in datapath).
- pcSource  out  2  00 ALU result, 01 ALUOut, 11 trap vector.
- MuxAlu1Sel  out  1  0 = PC, 1 = A.
- Mux4Sel  out  2  00 B, 01 const 4, 10 imm, 11 imm<<1.
- ALUOp  out  ALUOP_W  see package.
- IMemRead, DMemRead, wrMem  out  1 each  memory strobes.
- Load_ir, LoadMDR, regAWrite, regBWrite, AluOutWrite, regWrite  out  1 each  register loads.
- memtoReg  out  2  writeback source: 00 ALUOut, 01 MDR, 10 PC, 11 imm.
- epcWrite  out  1  save PC into EPC.
- illegalOp  out  1  one-cycle trap pulse.
- state_dbg  out  5  current state.

Behaviour:
- Reset (reset=0, async): state=RESET_WAIT; idle counter=RESET_IDLE; wait counter=0; all outputs 0. Reset mid-access aborts immediately. No write strobe may be asserted in the cycle after reset release.
- RESET_WAIT: outputs 0. Counter decrements each cycle; goes to FETCH when it reaches 1.
- Memory states (FETCH, MEM_RD, MEM_WR):
  - Each lasts MEM_LAT+1 cycles; the strobe is held every cycle.
  - Completion signals are asserted only in the last cycle (wait counter==0).
  - The counter loads MEM_LAT on entry.
- FETCH: IMemRead=1. Last cycle: Load_ir=1, pcWrite=1, pcSource=00, MuxAlu1Sel=0, Mux4Sel=01, ALUOp=ADD. Next: DECODE.
- DECODE: regAWrite=1, regBWrite=1, AluOutWrite=1, MuxAlu1Sel=0, Mux4Sel=11, ALUOp=ADD. This is the speculative branch target, computed from the already-incremented PC; the datapath owns any -4 correction. Next state by OpCode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH if Funct3 is 000 or 001, else TRAP
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other opcode -> TRAP
- EXEC_R: MuxAlu1Sel=1, Mux4Sel=00, ALUOp=FUNCT, AluOutWrite=1. Next: WB_ALU.
- EXEC_I: MuxAlu1Sel=1, Mux4Sel=10, ALUOp=FUNCT, AluOutWrite=1. Next: WB_ALU.
- ADDR: MuxAlu1Sel=1, Mux4Sel=10, ALUOp=ADD, AluOutWrite=1. Next: MEM_RD for load, MEM_WR for store.
- MEM_RD: DMemRead=1; LoadMDR=1 in last cycle. Next: WB_LOAD.
- WB_LOAD: regWrite=1, memtoReg=01. Next: FETCH.
- MEM_WR: wrMem=1 every cycle. Next: FETCH.
- WB_ALU: regWrite=1, memtoReg=00. Next: FETCH.
- BRANCH: MuxAlu1Sel=1, Mux4Sel=00, ALUOp=SUB, PCWriteCond=1, pcSource=01, BranchNeg=Funct3[0]. Next: FETCH.
- JAL: regWrite=1, memtoReg=10, pcWrite=1, pcSource=01. Next: FETCH.
- LUI: regWrite=1, memtoReg=11. Next: FETCH.
- TRAP: epcWrite=1, illegalOp=1, pcWrite=1, pcSource=11. Next: FETCH.
- Undefined state encoding: next state is FETCH, all outputs 0.
- OpCode and Funct3 are sampled only in DECODE and BRANCH; IR holds them stable otherwise.
- Per-instruction cycle counts with MEM_LAT=0: R/I 4, load 5, store 4, branch 3, jal 3, lui 3, trap 3. Each memory state adds MEM_LAT cycles.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum (5-bit);
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI;
  - ALUOp constants ALU_ADD=1, ALU_SUB=2, ALU_FUNCT=3;
  - mux-select constants.
- One sub-module, ctrl_wait_counter: load / decrement / zero-flag down-counter, used for both the idle period and memory wait states.

Test Plan:
- RESET_IDLE=3, MEM_LAT=0, release reset, R-type 0110011 -> 3 idle cycles with all outputs 0; FETCH with pcWrite=Load_ir=1; DECODE; EXEC_R; WB_ALU with regWrite=1, memtoReg=00; back to FETCH after 4 cycles.
- MEM_LAT=2, load 0000011 -> FETCH holds IMemRead 3 cycles with Load_ir only in the 3rd; MEM_RD holds DMemRead 3 cycles with LoadMDR only in the 3rd; total 9 cycles.
- Store 0100011, MEM_LAT=1 -> wrMem high exactly 2 cycles, regWrite never asserted.
- Branch 1100011: Funct3=001 -> BRANCH with PCWriteCond=1, BranchNeg=1, ALUOp=2. Funct3=010 -> TRAP with illegalOp pulse of 1 cycle and pcSource=11.
- Opcode 1111111 -> TRAP with epcWrite=1, then FETCH. Jal -> regWrite=1, memtoReg=10, pcWrite=1 in the same cycle.
- Assert reset during MEM_WR cycle 2 of 3 -> wrMem drops asynchronously, state_dbg=RESET_WAIT, no spurious strobes after release.

Source files
------------

// File: rtl/multicycle_ctrl_unit_pkg.sv
// rtl/multicycle_ctrl_unit_pkg.sv - shared types and encodings for the multicycle RV32 control unit
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET_WAIT = 5'd0,
        S_FETCH      = 5'd1,
        S_DECODE     = 5'd2,
        S_EXEC_R     = 5'd3,
        S_EXEC_I     = 5'd4,
        S_ADDR       = 5'd5,
        S_MEM_RD     = 5'd6,
        S_WB_LOAD    = 5'd7,
        S_MEM_WR     = 5'd8,
        S_WB_ALU     = 5'd9,
        S_BRANCH     = 5'd10,
        S_JAL        = 5'd11,
        S_LUI        = 5'd12,
        S_TRAP       = 5'd13
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int ALU_ADD   = 1;
    localparam int ALU_SUB   = 2;
    localparam int ALU_FUNCT = 3;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_TRAP   = 2'b11;

    localparam logic [1:0] MUX4_B      = 2'b00;
    localparam logic [1:0] MUX4_FOUR   = 2'b01;
    localparam logic [1:0] MUX4_IMM    = 2'b10;
    localparam logic [1:0] MUX4_IMM_SH = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;
    localparam logic [1:0] M2R_IMM    = 2'b11;

    localparam int WAIT_W = 4;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// rtl/ctrl_wait_counter.sv - loadable saturating down-counter with zero flag
module ctrl_wait_counter #(
    parameter int             W         = 4,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load wins over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// rtl/multicycle_ctrl_unit.sv - Moore control FSM for a multicycle RV32 core
module multicycle_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT    = 0,
    parameter int RESET_IDLE = 1,
    parameter int ALUOP_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         OpCode,
    input  logic [2:0]         Funct3,
    input  logic               Zero,
    output logic               pcWrite,
    output logic               PCWriteCond,
    output logic               BranchNeg,
    output logic [1:0]         pcSource,
    output logic               MuxAlu1Sel,
    output logic [1:0]         Mux4Sel,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               IMemRead,
    output logic               DMemRead,
    output logic               wrMem,
    output logic               Load_ir,
    output logic               LoadMDR,
    output logic               regAWrite,
    output logic               regBWrite,
    output logic               AluOutWrite,
    output logic               regWrite,
    output logic [1:0]         memtoReg,
    output logic               epcWrite,
    output logic               illegalOp,
    output logic [4:0]         state_dbg
);

    state_t              r_state, w_next;
    logic                r_is_store;
    logic [WAIT_W-1:0]   w_idle_cnt, w_unused_wait_cnt;
    logic                w_wait_zero, w_unused_idle_zero, w_wait_load;
    logic                w_unused;

    // Branch resolution happens in the datapath, so Zero is never consulted here.
    assign w_unused = Zero;

    ctrl_wait_counter #(.W(WAIT_W), .RESET_VAL(WAIT_W'(RESET_IDLE))) u_idle_cnt (
        .clk(clk), .rst_n(reset), .i_load(1'b0), .i_load_val('0),
        .i_dec(r_state == S_RESET_WAIT),
        .o_count(w_idle_cnt), .o_zero(w_unused_idle_zero)
    );

    assign w_wait_load = (w_next != r_state) && is_mem_state(w_next);

    ctrl_wait_counter #(.W(WAIT_W), .RESET_VAL('0)) u_wait_cnt (
        .clk(clk), .rst_n(reset), .i_load(w_wait_load), .i_load_val(WAIT_W'(MEM_LAT)),
        .i_dec(is_mem_state(r_state)),
        .o_count(w_unused_wait_cnt), .o_zero(w_wait_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_RESET_WAIT;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_is_store <= (OpCode == OP_STORE);
        end
    end

    assign state_dbg = r_state;

    always_comb begin
        w_next      = r_state;
        pcWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNeg   = 1'b0;
        pcSource    = PCSRC_ALU;
        MuxAlu1Sel  = 1'b0;
        Mux4Sel     = MUX4_B;
        ALUOp       = '0;
        IMemRead    = 1'b0;
        DMemRead    = 1'b0;
        wrMem       = 1'b0;
        Load_ir     = 1'b0;
        LoadMDR     = 1'b0;
        regAWrite   = 1'b0;
        regBWrite   = 1'b0;
        AluOutWrite = 1'b0;
        regWrite    = 1'b0;
        memtoReg    = M2R_ALUOUT;
        epcWrite    = 1'b0;
        illegalOp   = 1'b0;
        case (r_state)
            S_RESET_WAIT: if (w_idle_cnt <= WAIT_W'(1)) w_next = S_FETCH;
            S_FETCH: begin
                IMemRead = 1'b1;
                if (w_wait_zero) begin
                    Load_ir = 1'b1;
                    pcWrite = 1'b1;
                    Mux4Sel = MUX4_FOUR;
                    ALUOp   = ALUOP_W'(ALU_ADD);
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target; the datapath applies any -4 correction.
                regAWrite   = 1'b1;
                regBWrite   = 1'b1;
                AluOutWrite = 1'b1;
                Mux4Sel     = MUX4_IMM_SH;
                ALUOp       = ALUOP_W'(ALU_ADD);
                case (OpCode)
                    OP_R:               w_next = S_EXEC_R;
                    OP_I:               w_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  w_next = S_ADDR;
                    OP_BRANCH:          w_next = (Funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:             w_next = S_JAL;
                    OP_LUI:             w_next = S_LUI;
                    default:            w_next = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                MuxAlu1Sel  = 1'b1;
                Mux4Sel     = (r_state == S_EXEC_R) ? MUX4_B : MUX4_IMM;
                ALUOp       = ALUOP_W'(ALU_FUNCT);
                AluOutWrite = 1'b1;
                w_next      = S_WB_ALU;
            end
            S_ADDR: begin
                MuxAlu1Sel  = 1'b1;
                Mux4Sel     = MUX4_IMM;
                ALUOp       = ALUOP_W'(ALU_ADD);
                AluOutWrite = 1'b1;
                w_next      = r_is_store ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                DMemRead = 1'b1;
                if (w_wait_zero) begin
                    LoadMDR = 1'b1;
                    w_next  = S_WB_LOAD;
                end
            end
            S_WB_LOAD: begin
                regWrite = 1'b1;
                memtoReg = M2R_MDR;
                w_next   = S_FETCH;
            end
            S_MEM_WR: begin
                wrMem = 1'b1;
                if (w_wait_zero) w_next = S_FETCH;
            end
            S_WB_ALU: begin
                regWrite = 1'b1;
                memtoReg = M2R_ALUOUT;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                MuxAlu1Sel  = 1'b1;
                Mux4Sel     = MUX4_B;
                ALUOp       = ALUOP_W'(ALU_SUB);
                PCWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
                BranchNeg   = Funct3[0];
                w_next      = S_FETCH;
            end
            S_JAL: begin
                regWrite = 1'b1;
                memtoReg = M2R_PC;
                pcWrite  = 1'b1;
                pcSource = PCSRC_ALUOUT;
                w_next   = S_FETCH;
            end
            S_LUI: begin
                regWrite = 1'b1;
                memtoReg = M2R_IMM;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
                epcWrite  = 1'b1;
                illegalOp = 1'b1;
                pcWrite   = 1'b1;
                pcSource  = PCSRC_TRAP;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb/tb_multicycle_ctrl_unit.sv - directed and random instruction streams against a phase-list model
module tb_multicycle_ctrl_unit;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       pcw, pwc, bneg;
        logic [1:0] pcs;
        logic       a1;
        logic [1:0] m4;
        logic [2:0] aluop;
        logic       imr, dmr, wr, ldir, ldmdr, ra, rb, aow, rw;
        logic [1:0] m2r;
        logic       epc, ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       zero = 1'b0;
    logic [6:0] op [2];
    logic [2:0] f3 [2];
    ctl_t       obs [2];
    logic [4:0] sdbg [2];

    int   n_assert = 0;
    int   n_fail   = 0;
    ctl_t exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT  = (g == 0) ? 0 : 2;
        localparam int IDLE = (g == 0) ? 3 : 1;
        logic       pcw, pwc, bneg, a1, imr, dmr, wr, ldir, ldmdr, ra, rb, aow, rw, epc, ill;
        logic [1:0] pcs, m4, m2r;
        logic [2:0] aluop;
        logic [4:0] st;
        multicycle_ctrl_unit #(.MEM_LAT(LAT), .RESET_IDLE(IDLE), .ALUOP_W(3)) u_dut (
            .clk(clk), .reset(reset), .OpCode(op[g]), .Funct3(f3[g]), .Zero(zero),
            .pcWrite(pcw), .PCWriteCond(pwc), .BranchNeg(bneg), .pcSource(pcs),
            .MuxAlu1Sel(a1), .Mux4Sel(m4), .ALUOp(aluop), .IMemRead(imr), .DMemRead(dmr),
            .wrMem(wr), .Load_ir(ldir), .LoadMDR(ldmdr), .regAWrite(ra), .regBWrite(rb),
            .AluOutWrite(aow), .regWrite(rw), .memtoReg(m2r), .epcWrite(epc),
            .illegalOp(ill), .state_dbg(st)
        );
        assign obs[g]  = {pcw, pwc, bneg, pcs, a1, m4, aluop, imr, dmr, wr, ldir, ldmdr,
                          ra, rb, aow, rw, m2r, epc, ill};
        assign sdbg[g] = st;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int idle_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                         7'b1100011, 7'b1101111, 7'b0110111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expected per-cycle control words for one instruction, phase by phase.
    task automatic build(input logic [6:0] opc, input logic [2:0] fn, input int lat);
        ctl_t c;
        exp_q.delete();
        for (int i = 0; i < lat; i++) begin c = '0; c.imr = 1; exp_q.push_back(c); end
        c = '0; c.imr = 1; c.ldir = 1; c.pcw = 1; c.m4 = 2'b01; c.aluop = 3'd1; exp_q.push_back(c);
        c = '0; c.ra = 1; c.rb = 1; c.aow = 1; c.m4 = 2'b11; c.aluop = 3'd1; exp_q.push_back(c);
        if (opc == 7'b0110011 || opc == 7'b0010011) begin
            c = '0; c.a1 = 1; c.aow = 1; c.aluop = 3'd3;
            c.m4 = (opc == 7'b0110011) ? 2'b00 : 2'b10;
            exp_q.push_back(c);
            c = '0; c.rw = 1; exp_q.push_back(c);
        end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
            c = '0; c.a1 = 1; c.m4 = 2'b10; c.aluop = 3'd1; c.aow = 1; exp_q.push_back(c);
            if (opc == 7'b0000011) begin
                for (int i = 0; i < lat; i++) begin c = '0; c.dmr = 1; exp_q.push_back(c); end
                c = '0; c.dmr = 1; c.ldmdr = 1; exp_q.push_back(c);
                c = '0; c.rw = 1; c.m2r = 2'b01; exp_q.push_back(c);
            end else begin
                for (int i = 0; i <= lat; i++) begin c = '0; c.wr = 1; exp_q.push_back(c); end
            end
        end else if (opc == 7'b1100011 && fn <= 3'd1) begin
            c = '0; c.a1 = 1; c.aluop = 3'd2; c.pwc = 1; c.pcs = 2'b01; c.bneg = fn[0];
            exp_q.push_back(c);
        end else if (opc == 7'b1101111) begin
            c = '0; c.rw = 1; c.m2r = 2'b10; c.pcw = 1; c.pcs = 2'b01; exp_q.push_back(c);
        end else if (opc == 7'b0110111) begin
            c = '0; c.rw = 1; c.m2r = 2'b11; exp_q.push_back(c);
        end else begin
            c = '0; c.epc = 1; c.ill = 1; c.pcw = 1; c.pcs = 2'b11; exp_q.push_back(c);
        end
    endtask

    // Entered at a negedge while the DUT is in its first FETCH cycle.
    task automatic run_instr(input int d, input logic [6:0] opc, input logic [2:0] fn, input string tag);
        op[d] = opc;
        f3[d] = fn;
        build(opc, fn, lat_of(d));
        foreach (exp_q[i]) begin
            #1 chk($sformatf("%s_d%0d_c%0d", tag, d, i), 32'(obs[d]), 32'(exp_q[i]));
            @(negedge clk);
        end
    endtask

    task automatic release_and_idle(input int d);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < idle_of(d); i++) begin
            #1 chk($sformatf("idle_out_d%0d_c%0d", d, i), 32'(obs[d]), 32'd0);
            chk($sformatf("idle_state_d%0d_c%0d", d, i), 32'(sdbg[d]), 32'(S_RESET_WAIT));
            @(negedge clk);
        end
    endtask

    task automatic run_random(input int d, input int n);
        logic [6:0] o;
        logic [2:0] fn;
        for (int k = 0; k < n; k++) begin
            fn = 3'($urandom);
            case ($urandom_range(0, 8))
                0: o = 7'b0110011;
                1: o = 7'b0010011;
                2: o = 7'b0000011;
                3: o = 7'b0100011;
                4: begin o = 7'b1100011; fn = 3'($urandom_range(0, 1)); end
                5: o = 7'b1100011;
                6: o = 7'b1101111;
                7: o = 7'b0110111;
                default: begin
                    o = 7'($urandom);
                    while (is_legal(o)) o = 7'($urandom);
                end
            endcase
            run_instr(d, o, fn, "rand");
        end
    endtask

    initial begin
        op[0] = 7'b0110011; op[1] = 7'b0110011;
        f3[0] = 3'd0;       f3[1] = 3'd0;
        repeat (2) @(negedge clk);
        #1 chk("reset_out_d0", 32'(obs[0]), 32'd0);
        chk("reset_state_d0", 32'(sdbg[0]), 32'(S_RESET_WAIT));

        // MEM_LAT=0, RESET_IDLE=3
        release_and_idle(0);
        run_instr(0, 7'b0110011, 3'd0, "rtype");
        run_instr(0, 7'b0000011, 3'd2, "load");
        run_instr(0, 7'b0100011, 3'd2, "store");
        run_instr(0, 7'b1100011, 3'd1, "bne");
        run_instr(0, 7'b1100011, 3'd0, "beq");
        run_instr(0, 7'b1100011, 3'd2, "badbr");
        run_instr(0, 7'b1111111, 3'd0, "illop");
        run_instr(0, 7'b1101111, 3'd0, "jal");
        run_instr(0, 7'b0110111, 3'd0, "lui");
        run_random(0, 30);

        // MEM_LAT=2, RESET_IDLE=1
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset_out_d1", 32'(obs[1]), 32'd0);
        release_and_idle(1);
        run_instr(1, 7'b0000011, 3'd2, "load_lat");
        run_instr(1, 7'b0100011, 3'd2, "store_lat");
        run_instr(1, 7'b0010011, 3'd5, "itype_lat");
        run_random(1, 30);

        // Reset asserted during the second MEM_WR cycle of a store.
        op[1] = 7'b0100011;
        f3[1] = 3'd2;
        build(7'b0100011, 3'd2, 2);
        for (int i = 0; i <= 6; i++) begin
            #1 chk($sformatf("abort_d1_c%0d", i), 32'(obs[1]), 32'(exp_q[i]));
            if (i < 6) @(negedge clk);
        end
        #2 reset = 1'b0;
        #1 chk("abort_wrmem", 32'(obs[1].wr), 32'd0);
        chk("abort_out", 32'(obs[1]), 32'd0);
        chk("abort_state", 32'(sdbg[1]), 32'(S_RESET_WAIT));
        @(negedge clk);
        release_and_idle(1);
        run_instr(1, 7'b1100011, 3'd1, "post_abort_bne");
        run_random(1, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
